// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: owns PCF, runs the req/ack handshake with instruction memory and
// drives the Fetch->Decode register, parking one word in a skid buffer while Decode stalls.
module fetch_controller #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic        StallD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD,
    output logic [31:0] PCF
);

    typedef enum logic [1:0] {StIdle, StReq, StHold, StKill} stateT;

    stateT       stateQ, stateD;
    logic [31:0] pcfQ, pcfD;
    logic [31:0] pendingQ, pendingD;
    logic [31:0] skidInstrQ, skidInstrD;
    logic [31:0] skidPcQ, skidPcD;
    logic [31:0] instrDQ, instrDD;
    logic [31:0] pcDQ, pcDD;
    logic [31:0] pcPlus4DQ, pcPlus4DD;
    logic        validDQ, validDD;
    logic [31:0] pcPlus4F;

    assign pcPlus4F = pcfQ + 32'd4;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ     <= StIdle;
            pcfQ       <= RESET_PC;
            pendingQ   <= 32'h0;
            skidInstrQ <= 32'h0;
            skidPcQ    <= 32'h0;
            instrDQ    <= 32'h0;
            pcDQ       <= 32'h0;
            pcPlus4DQ  <= 32'h0;
            validDQ    <= 1'b0;
        end else begin
            stateQ     <= stateD;
            pcfQ       <= pcfD;
            pendingQ   <= pendingD;
            skidInstrQ <= skidInstrD;
            skidPcQ    <= skidPcD;
            instrDQ    <= instrDD;
            pcDQ       <= pcDD;
            pcPlus4DQ  <= pcPlus4DD;
            validDQ    <= validDD;
        end
    end

    always_comb begin
        stateD     = stateQ;
        pcfD       = pcfQ;
        pendingD   = pendingQ;
        skidInstrD = skidInstrQ;
        skidPcD    = skidPcQ;
        instrDD    = instrDQ;
        pcDD       = pcDQ;
        pcPlus4DD  = pcPlus4DQ;
        validDD    = validDQ;
        imem_req   = 1'b0;

        unique case (stateQ)
            StIdle: stateD = StReq;
            StReq: begin
                imem_req = 1'b1;
                if (PCSrcE) begin
                    if (imem_ack) begin
                        pcfD = PCTargetE;
                    end else begin
                        pendingD = PCTargetE;
                        stateD   = StKill;
                    end
                end else if (imem_ack) begin
                    pcfD = pcPlus4F;
                    if (StallD) begin
                        skidInstrD = imem_rdata;
                        skidPcD    = pcfQ;
                        stateD     = StHold;
                    end else begin
                        instrDD   = imem_rdata;
                        pcDD      = pcfQ;
                        pcPlus4DD = pcPlus4F;
                        validDD   = 1'b1;
                    end
                end else if (!StallD) begin
                    instrDD = NOP_INSTR;
                    validDD = 1'b0;
                end
            end
            StHold: begin
                if (PCSrcE) begin
                    pcfD   = PCTargetE;
                    stateD = StReq;
                end else if (!StallD) begin
                    instrDD   = skidInstrQ;
                    pcDD      = skidPcQ;
                    pcPlus4DD = skidPcQ + 32'd4;
                    validDD   = 1'b1;
                    stateD    = StReq;
                end
            end
            StKill: begin
                // pcfQ still holds the abandoned address, keeping imem_addr stable until ack
                imem_req = 1'b1;
                if (imem_ack) begin
                    pcfD   = PCSrcE ? PCTargetE : pendingQ;
                    stateD = StReq;
                end else if (PCSrcE) begin
                    pendingD = PCTargetE;
                end else if (!StallD) begin
                    instrDD = NOP_INSTR;
                    validDD = 1'b0;
                end
            end
            default: stateD = StIdle;
        endcase

        if (PCSrcE) begin
            instrDD = NOP_INSTR;
            validDD = 1'b0;
        end
    end

    assign imem_addr = pcfQ;
    assign PCF       = pcfQ;
    assign InstrD    = instrDQ;
    assign PCD       = pcDQ;
    assign PCPlus4D  = pcPlus4DQ;
    assign ValidD    = validDQ;

endmodule
